// File: rtl/sensor_pkg.sv
// Shared definitions for the HC-SR04 ultrasonic ranger and its downstream
// distance-mapping logic: FSM encoding, clamp bounds and the index mapping.
package sensor_pkg;

    typedef enum logic [2:0] {
        ESPERA     = 3'd0,
        DISPARO    = 3'd1,
        ESPERA_ECO = 3'd2,
        MIDE       = 3'd3,
        CALC       = 3'd4
    } estado_t;

    localparam int          CM_BITS     = 9;
    localparam logic [8:0]  CM_MAX      = 9'd511;
    localparam logic [8:0]  DIST_MIN_CM = 9'd5;
    localparam logic [8:0]  DIST_MAX_CM = 9'd15;
    localparam logic [8:0]  IDX_MAX     = 9'd10;

    // Map a distance in cm onto the ROM index 0..IDX_MAX (distance minus 5 cm, clamped).
    function automatic logic [8:0] mapear_distancia(input logic [8:0] cm);
        if (cm <= DIST_MIN_CM)
            return '0;
        else if (cm >= DIST_MAX_CM)
            return IDX_MAX;
        else
            return cm - DIST_MIN_CM;
    endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sincronizador (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first stage a full cycle to settle.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sensor_ultrasonico.sv
// HC-SR04 controller: periodic trigger pulse, echo-width measurement in whole
// centimetres, timeout detection and mapping to a 0..10 ROM index.
module sensor_ultrasonico
    import sensor_pkg::*;
#(
    parameter int unsigned TRIG_CYC    = 1000,
    parameter int unsigned CYC_PER_CM  = 5800,
    parameter int unsigned PERIOD_CYC  = 6000000,
    parameter int unsigned TIMEOUT_CYC = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       echo,
    output logic       trigger,
    output logic [8:0] distancia,
    output logic [8:0] distancia_cm,
    output logic       valido,
    output logic       sin_eco
);

    localparam logic [31:0] TRIG_M1    = 32'(TRIG_CYC - 1);
    localparam logic [31:0] CPC_M1     = 32'(CYC_PER_CM - 1);
    localparam logic [31:0] PERIOD_M1  = 32'(PERIOD_CYC - 1);
    localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT_CYC - 1);

    estado_t     state, state_n;
    logic        echo_s, echo_d, echo_rise;
    logic [31:0] cnt, presc, presc_n;
    logic [8:0]  cm, cm_n;
    logic        cnt_clr, inicia, fin_ok, fin_to;

    sincronizador u_sync (
        .clk (clk),
        .rst (rst),
        .d   (echo),
        .q   (echo_s)
    );

    assign echo_rise = echo_s & ~echo_d;
    assign trigger   = (state == DISPARO);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ESPERA;
        else     state <= state_n;
    end

    // Next-state decode and single-cycle control strobes.
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_n = state;
        cnt_clr = 1'b0;
        inicia  = 1'b0;
        fin_ok  = 1'b0;
        fin_to  = 1'b0;
        case (state)
            ESPERA: if (cnt == PERIOD_M1) begin
                state_n = DISPARO;
                cnt_clr = 1'b1;
            end
            DISPARO: if (cnt == TRIG_M1) begin
                state_n = ESPERA_ECO;
                cnt_clr = 1'b1;
            end
            ESPERA_ECO: begin
                if (echo_rise) begin
                    state_n = MIDE;
                    inicia  = 1'b1;
                end else if (cnt == TIMEOUT_M1) begin
                    state_n = ESPERA;
                    cnt_clr = 1'b1;
                    fin_to  = 1'b1;
                end
            end
            MIDE: begin
                if (!echo_s) begin
                    state_n = CALC;
                end else if (cnt == TIMEOUT_M1) begin
                    state_n = ESPERA;
                    cnt_clr = 1'b1;
                    fin_to  = 1'b1;
                end
            end
            CALC: begin
                state_n = ESPERA;
                cnt_clr = 1'b1;
                fin_ok  = 1'b1;
            end
            default: begin
                state_n = ESPERA;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Prescaler step; the rising-edge cycle already counts as one echo-high cycle.
    always_comb begin
        logic [31:0] p_src;
        logic [8:0]  c_src;
        p_src   = inicia ? 32'd0 : presc;
        c_src   = inicia ? 9'd0  : cm;
        presc_n = p_src + 32'd1;
        cm_n    = c_src;
        if (p_src == CPC_M1) begin
            presc_n = '0;
            cm_n    = (c_src == CM_MAX) ? c_src : c_src + 9'd1;
        end
    end

    // Counters, edge-detect history and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_d       <= 1'b0;
            cnt          <= '0;
            presc        <= '0;
            cm           <= '0;
            distancia    <= '0;
            distancia_cm <= '0;
            valido       <= 1'b0;
            sin_eco      <= 1'b0;
        end else begin
            echo_d <= echo_s;
            if (cnt_clr)     cnt <= '0;
            else if (inicia) cnt <= 32'd1;
            else             cnt <= cnt + 32'd1;
            if (inicia || (state == MIDE && echo_s)) begin
                presc <= presc_n;
                cm    <= cm_n;
            end
            valido  <= fin_ok;
            sin_eco <= fin_to;
            if (fin_ok) begin
                distancia_cm <= cm;
                distancia    <= mapear_distancia(cm);
            end
        end
    end

endmodule

// File: tb/tb_sensor_ultrasonico.sv
// Directed testbench for sensor_ultrasonico using shortened timing parameters.
module tb_sensor_ultrasonico;

    localparam int P     = 100;
    localparam int T     = 5;
    localparam int C     = 10;
    localparam int TO    = 300;
    localparam int BOUND = 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       echo = 1'b0;
    logic       trigger, valido, sin_eco;
    logic [8:0] distancia, distancia_cm;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt = 0, sin_cnt = 0, both_cnt = 0;
    int exp_valid = 0, exp_sin = 0;

    sensor_ultrasonico #(
        .TRIG_CYC    (T),
        .CYC_PER_CM  (C),
        .PERIOD_CYC  (P),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .echo         (echo),
        .trigger      (trigger),
        .distancia    (distancia),
        .distancia_cm (distancia_cm),
        .valido       (valido),
        .sin_eco      (sin_eco)
    );

    always #5 clk = ~clk;

    // Pulse monitor on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (valido)            valid_cnt++;
            if (sin_eco)           sin_cnt++;
            if (valido && sin_eco) both_cnt++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_trig(input string tag, input logic level);
        int n;
        n = 0;
        while (trigger !== level && n < BOUND) begin
            tick();
            n++;
        end
        if (n >= BOUND) check({tag, " trigger_wait"}, int'(trigger), int'(level));
    endtask

    task automatic wait_sin_eco(input string tag);
        int k;
        k = 0;
        while (sin_eco !== 1'b1 && k < TO + 20) begin
            tick();
            k++;
        end
        check({tag, " latency"}, k, TO);
        check({tag, " valido"}, int'(valido), 0);
    endtask

    // One full trigger/echo cycle: echo rises d cycles after trigger falls, lasts n cycles.
    task automatic measure(input string tag, input int d, input int n,
                           input int exp_cm, input int exp_idx);
        int k, m;
        wait_trig(tag, 1'b1);
        wait_trig(tag, 1'b0);
        repeat (d) tick();
        echo = 1'b1;
        repeat (n) tick();
        echo = 1'b0;
        k = d + n;
        while (valido !== 1'b1 && k < d + n + 50) begin
            tick();
            k++;
        end
        check({tag, " latency"}, k, d + n + 4);
        check({tag, " cm"}, int'(distancia_cm), exp_cm);
        check({tag, " idx"}, int'(distancia), exp_idx);
        check({tag, " idx_hi"}, int'(distancia[8:4]), 0);
        check({tag, " sin_eco"}, int'(sin_eco), 0);
        tick();
        check({tag, " valido_width"}, int'(valido), 0);
        m = 1;
        while (trigger !== 1'b1 && m < BOUND) begin
            tick();
            m++;
        end
        check({tag, " spacing"}, m, P);
        exp_valid++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, w, vc, sc;

        repeat (3) tick();
        check("rst trigger", int'(trigger), 0);
        check("rst cm", int'(distancia_cm), 0);
        check("rst idx", int'(distancia), 0);
        check("rst valido", int'(valido), 0);
        check("rst sin_eco", int'(sin_eco), 0);
        @(negedge clk);
        rst = 1'b0;

        measure("m10cm",  3, 100, 10, 5);
        measure("m3cm",   2,  30,  3, 0);
        measure("m20cm",  4, 200, 20, 10);
        measure("m109",   3, 109, 10, 5);
        measure("m110",   3, 110, 11, 6);
        measure("m5cm",   1,  50,  5, 0);
        measure("m6cm",   5,  60,  6, 1);
        measure("m149",   2, 149, 14, 9);
        measure("m150",   2, 150, 15, 10);

        // No echo at all: timeout, data held.
        wait_trig("noecho", 1'b1);
        wait_trig("noecho", 1'b0);
        wait_sin_eco("noecho");
        check("noecho cm_hold", int'(distancia_cm), 15);
        check("noecho idx_hold", int'(distancia), 10);
        exp_sin++;

        // Echo already high before the trigger: no measurement.
        echo = 1'b1;
        wait_trig("stuck", 1'b1);
        wait_trig("stuck", 1'b0);
        wait_sin_eco("stuck");
        check("stuck cm_hold", int'(distancia_cm), 15);
        echo = 1'b0;
        exp_sin++;

        // Reset in the middle of the trigger pulse.
        wait_trig("rst_disp", 1'b1);
        tick();
        tick();
        vc = valid_cnt;
        sc = sin_cnt;
        #2 rst = 1'b1;
        #1;
        check("rst_disp trigger", int'(trigger), 0);
        check("rst_disp cm", int'(distancia_cm), 0);
        check("rst_disp idx", int'(distancia), 0);
        repeat (3) tick();
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (trigger !== 1'b1 && n < BOUND) begin
            tick();
            n++;
        end
        check("rst_disp restart", n, P);
        w = 0;
        while (trigger === 1'b1 && w < BOUND) begin
            tick();
            w++;
        end
        check("rst_disp width", w, T);

        // Reset while an echo is being measured.
        repeat (2) tick();
        echo = 1'b1;
        repeat (40) tick();
        #2 rst = 1'b1;
        #1;
        echo = 1'b0;
        check("rst_mide cm", int'(distancia_cm), 0);
        check("rst_mide valido", int'(valido), 0);
        repeat (3) tick();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) tick();
        check("rst_abort valido_cnt", valid_cnt, vc);
        check("rst_abort sin_cnt", sin_cnt, sc);

        check("valido_count", valid_cnt, exp_valid);
        check("sin_eco_count", sin_cnt, exp_sin);
        check("valido_and_sin_eco", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sensor_ultrasonico.md
SENSOR_ULTRASONICO -- requirements
Module: sensor_ultrasonico

Interface
REQ-001 Parameter TRIG_CYC, default 1000; trigger pulse width in clk cycles (10 us at 100 MHz).
REQ-002 Parameter CYC_PER_CM, default 5800; clk cycles of echo-high per 1 cm of distance (58 us round trip).
REQ-003 Parameter PERIOD_CYC, default 6000000; cycles spent in ESPERA before each trigger (60 ms).
REQ-004 Parameter TIMEOUT_CYC, default 2500000; maximum cycles waiting for an echo rise, and maximum echo-high duration (25 ms).
REQ-005 Port clk  input  1  system clock, single clock domain.
REQ-006 Port rst  input  1  reset, asynchronous, active-high.
REQ-007 Port echo  input  1  HC-SR04 echo line, asynchronous to clk.
REQ-008 Port trigger  output  1  HC-SR04 trigger line.
REQ-009 Port distancia  output  9  mapping index 0..10 (distance minus 5 cm, clamped), feeds the distance-mapping ROM address.
REQ-010 Port distancia_cm  output  9  raw measured distance in whole cm, saturating at 511.
REQ-011 Port valido  output  1  one-cycle pulse; distancia and distancia_cm updated this cycle.
REQ-012 Port sin_eco  output  1  one-cycle pulse; measurement aborted by timeout.

Function
REQ-013 echo SHALL pass through a 2-FF synchronizer; all edge detection uses the synchronized signal (2-cycle input latency).
REQ-014 FSM states SHALL be ESPERA, DISPARO, ESPERA_ECO, MIDE, CALC.
REQ-015 ESPERA: period counter counts from 0 on entry; after PERIOD_CYC cycles -> DISPARO.
REQ-016 DISPARO: trigger SHALL be 1 for exactly TRIG_CYC consecutive cycles, then -> ESPERA_ECO; trigger is 0 in all other states.
REQ-017 ESPERA_ECO: only a 0->1 transition of synchronized echo -> MIDE; echo already high on entry SHALL NOT start a measurement.
REQ-018 ESPERA_ECO: no rise within TIMEOUT_CYC cycles -> sin_eco pulse, -> ESPERA, data outputs unchanged.
REQ-019 MIDE: entry clears prescaler and cm counter; prescaler counts each cycle echo is high, wraps at CYC_PER_CM-1 and increments cm counter, which saturates at 511.
REQ-020 MIDE: synchronized echo 1->0 -> CALC; echo high for TIMEOUT_CYC cycles -> sin_eco pulse, -> ESPERA, data outputs unchanged.
REQ-021 CALC (one cycle): distancia_cm <= cm count (floor, partial cm discarded); distancia <= 0 if cm<=5, 10 if cm>=15, else cm-5; valido=1; -> ESPERA.
REQ-022 distancia SHALL never exceed 10; bits [8:4] SHALL always be 0.
REQ-023 Data outputs SHALL hold their last value between valido pulses.
REQ-024 valido and sin_eco SHALL never be 1 in the same cycle.

Reset
REQ-025 rst SHALL immediately force state ESPERA, all counters 0, trigger 0, distancia 0, distancia_cm 0, valido 0, sin_eco 0, synchronizer flops 0.
REQ-026 rst asserted mid-DISPARO or mid-MIDE SHALL abort without any valido/sin_eco pulse; after release the first trigger starts PERIOD_CYC cycles later.

Structure
REQ-027 State encodings and the clamp bounds (5 cm, 15 cm, index max 10) SHALL live in shared package sensor_pkg, reused by downstream mapping logic.
REQ-028 The echo synchronizer SHALL be a separate sub-module sincronizador (2-FF, 1-bit, async-high reset).

Verification
REQ-029 Defaults, echo high 58000 cycles after trigger -> valido, distancia_cm=10, distancia=5.
REQ-030 Echo high 20000 cycles (3 cm) -> distancia_cm=3, distancia=0; echo high 116000 (20 cm) -> distancia_cm=20, distancia=10.
REQ-031 Echo high 63799 cycles -> distancia_cm=10 (floor), distancia=5; 63800 -> 11, 6.
REQ-032 No echo after trigger -> sin_eco pulse 2500000 cycles after trigger falls, no valido, outputs keep prior value; echo stuck high -> no measurement, sin_eco.
REQ-033 rst asserted at cycle 500 of DISPARO -> trigger 0 same cycle, no valido; trigger reasserts exactly PERIOD_CYC cycles after release, width TRIG_CYC.
REQ-034 Overridden PERIOD_CYC=100, TRIG_CYC=5, CYC_PER_CM=10: back-to-back measurements, trigger spacing and valido count checked over 20 cycles of operation.
